// File: rtl/monitor_pressao_hist.sv
// monitor_pressao_hist: pressure alarm monitor with hysteresis and persistence.
// Classifies each valid pressure sample as NORMAL/BAIXO/ALTO, changes state only
// after PERSISTENCIA consecutive qualifying samples, keeps a sticky alarm flag
// cleared by operator acknowledge, and optionally counts alarm entries.
// Optional feature macro: MONITOR_PRESSAO_EVENTOS_EN (event counter compiled in).
module monitor_pressao_hist #(
  parameter int unsigned N            = 8,
  parameter int unsigned LIMITE_BAIXO = 50,
  parameter int unsigned LIMITE_ALTO  = 150,
  parameter int unsigned HISTERESE    = 5,
  parameter int unsigned PERSISTENCIA = 3,
  parameter int unsigned C            = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         amostra_valida,
  input  logic [N-1:0] pressao,
  input  logic         reconhece,
  output logic [1:0]   alerta,
  output logic         alarme_travado,
  output logic [C-1:0] num_eventos
);

  // Thresholds are compared in N+1 bits so limit+margin never wraps.
  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] lim_baixo     = W'(LIMITE_BAIXO);
  localparam logic [W-1:0] lim_baixo_sai = W'(LIMITE_BAIXO + HISTERESE);
  localparam logic [W-1:0] lim_alto      = W'(LIMITE_ALTO);
  localparam logic [W-1:0] lim_alto_sai  = W'(LIMITE_ALTO - HISTERESE);
  localparam logic [7:0]   persist       = 8'(PERSISTENCIA);

  // Exit margins must not overlap, otherwise NORMAL has no valid band.
  if (int'(LIMITE_BAIXO + HISTERESE) > int'(LIMITE_ALTO) - int'(HISTERESE)) begin : g_cfg_limites
    $error("monitor_pressao_hist: LIMITE_BAIXO+HISTERESE exceeds LIMITE_ALTO-HISTERESE");
  end

  // The streak counter is 8 bits wide, so the persistence must fit in 1..255.
  if (PERSISTENCIA == 0 || PERSISTENCIA > 255) begin : g_cfg_persist
    $error("monitor_pressao_hist: PERSISTENCIA must be in 1..255");
  end

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAIXO  = 2'b01,
    ALTO   = 2'b10
  } estado_t;

  estado_t        estado;
  estado_t        estado_nx;
  estado_t        pendente;
  estado_t        pendente_nx;
  estado_t        candidato;
  logic [7:0]     seq;
  logic [7:0]     seq_nx;
  logic [W-1:0]   p_ext;
  logic           entrada;

  // Candidate state for the current sample, relative to the current state.
  always_comb begin
    p_ext     = W'(pressao);
    candidato = estado;
    case (estado)
      NORMAL: begin
        if (p_ext < lim_baixo)       candidato = BAIXO;
        else if (p_ext >= lim_alto)  candidato = ALTO;
        else                         candidato = NORMAL;
      end
      BAIXO: begin
        if (p_ext >= lim_alto)           candidato = ALTO;
        else if (p_ext >= lim_baixo_sai) candidato = NORMAL;
        else                             candidato = BAIXO;
      end
      ALTO: begin
        if (p_ext < lim_baixo)          candidato = BAIXO;
        else if (p_ext < lim_alto_sai)  candidato = NORMAL;
        else                            candidato = ALTO;
      end
      default: candidato = NORMAL;
    endcase
  end

  // Next state, pending target and streak length; invalid cycles hold everything.
  always_comb begin
    estado_nx   = estado;
    pendente_nx = pendente;
    seq_nx      = seq;
    if (amostra_valida) begin
      if (candidato == estado) begin
        seq_nx = '0;
      end else begin
        if (candidato == pendente) begin
          seq_nx = seq + 8'd1;
        end else begin
          pendente_nx = candidato;
          seq_nx      = 8'd1;
        end
        if (seq_nx == persist) begin
          estado_nx = candidato;
          seq_nx    = '0;
        end
      end
    end
    entrada = (estado_nx != estado) && (estado_nx != NORMAL);
  end

  // State, pending target and streak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= NORMAL;
      pendente <= NORMAL;
      seq      <= '0;
    end else begin
      estado   <= estado_nx;
      pendente <= pendente_nx;
      seq      <= seq_nx;
    end
  end

  assign alerta = estado;

  // Sticky alarm: set on any alarm entry, acknowledged only while NORMAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarme_travado <= 1'b0;
    end else if (entrada) begin
      alarme_travado <= 1'b1;
    end else if (reconhece && (estado == NORMAL)) begin
      alarme_travado <= 1'b0;
    end
  end

`ifdef MONITOR_PRESSAO_EVENTOS_EN
  // Saturating count of alarm entries (including direct BAIXO<->ALTO moves).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_eventos <= '0;
    end else if (entrada && (num_eventos != '1)) begin
      num_eventos <= num_eventos + C'(1);
    end
  end
`else
  assign num_eventos = '0;
`endif

endmodule

// File: doc/monitor_pressao_hist.md
MONITOR_PRESSAO_HIST -- requirements
Module: monitor_pressao_hist

Interface
REQ-001 SHALL have parameter N, default 8: pressure sample width in bits.
REQ-002 SHALL have parameter LIMITE_BAIXO, default 50: low threshold; a sample below it is low.
REQ-003 SHALL have parameter LIMITE_ALTO, default 150: high threshold; a sample at or above it is high.
REQ-004 SHALL have parameter HISTERESE, default 5: exit margin for leaving an alarm state.
REQ-005 SHALL have parameter PERSISTENCIA, default 3, range 1..255: consecutive qualifying samples needed to change state.
REQ-006 SHALL have parameter C, default 8: event counter width.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port amostra_valida, input, 1 bit: pressao is sampled on this cycle.
REQ-010 SHALL have port pressao, input, N bits: unsigned sensor reading.
REQ-011 SHALL have port reconhece, input, 1 bit: operator acknowledge, sampled every cycle.
REQ-012 SHALL have port alerta, output, 2 bits: registered state; 00 NORMAL, 01 BAIXO, 10 ALTO; 11 never driven.
REQ-013 SHALL have port alarme_travado, output, 1 bit: sticky alarm flag.
REQ-014 SHALL have port num_eventos, output, C bits: count of alarm entries.

Function
REQ-015 SHALL implement a 3-state FSM (NORMAL, BAIXO, ALTO) and drive alerta directly from the state register.
REQ-016 SHALL compute the candidate state per valid sample in NORMAL as: p<LIMITE_BAIXO gives BAIXO; p>=LIMITE_ALTO gives ALTO; otherwise NORMAL.
REQ-017 SHALL compute the candidate state in BAIXO as: p>=LIMITE_ALTO gives ALTO; p>=LIMITE_BAIXO+HISTERESE gives NORMAL; otherwise BAIXO.
REQ-018 SHALL compute the candidate state in ALTO as: p<LIMITE_BAIXO gives BAIXO; p<LIMITE_ALTO-HISTERESE gives NORMAL; otherwise ALTO.
REQ-019 SHALL evaluate all threshold arithmetic in N+1 bits, with no wrap-around.
REQ-020 SHALL track a pending target and an 8-bit streak counter.
- candidate equal to state: counter cleared.
- candidate equal to pending: counter incremented.
- otherwise: pending set to candidate, counter set to 1.
REQ-021 SHALL load the state with the candidate on the edge at which the streak reaches PERSISTENCIA, and clear the counter on that edge.
- Latency: alerta changes one cycle after the PERSISTENCIA-th qualifying sample.
- With PERSISTENCIA=1 a single sample suffices.
REQ-022 SHALL, on cycles with amostra_valida=0, hold state, pending target and counter unchanged; an invalid cycle does not break a streak.
REQ-023 SHALL, on a direct BAIXO-to-ALTO or ALTO-to-BAIXO transition, count it as an alarm entry.
REQ-024 SHALL set alarme_travado on any edge where the state enters BAIXO or ALTO.
REQ-025 SHALL clear alarme_travado when reconhece=1 and alerta=00; reconhece SHALL be ignored while alerta is not 00.
REQ-026 SHALL give set priority when an alarm entry and reconhece occur on the same edge.
REQ-027 SHALL make num_eventos saturate at all-ones, never wrapping.
REQ-028 SHALL treat LIMITE_BAIXO+HISTERESE > LIMITE_ALTO-HISTERESE as an illegal configuration and flag it with an elaboration-time $error.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: state NORMAL (alerta=00), alarme_travado=0, num_eventos=0, counter=0, pending=NORMAL.
REQ-030 SHALL, on reset asserted mid-streak or mid-alarm, discard all progress; the first valid sample after release starts a new streak.

Configuration
REQ-031 SHALL use macro MONITOR_PRESSAO_EVENTOS_EN to compile the event counter in or out.
- Defined: num_eventos behaves per REQ-023 and REQ-027.
- Undefined: no counter logic; num_eventos is tied to 0.
- REQ-001..REQ-026 are unaffected either way.

Verification (N=8, 50/150, HISTERESE=5, PERSISTENCIA=3, macro defined)
REQ-032 SHALL cover: valid samples 30,30,30 -> alerta 00,00, then 01 after the third; alarme_travado=1; num_eventos=1.
REQ-033 SHALL cover: in BAIXO, samples 52,53,54 -> alerta stays 01 (hysteresis); then 55,55,55 -> alerta 00.
REQ-034 SHALL cover: samples 160,160, then amostra_valida=0 for 4 cycles, then 160 -> alerta 10 after the third valid sample.
REQ-035 SHALL cover: samples 160,160,70 -> no transition; then 150,150,150 -> alerta 10 (boundary at the limit).
REQ-036 SHALL cover: in ALTO, reconhece=1 -> alarme_travado stays 1; return to NORMAL, then reconhece=1 -> alarme_travado 0 on the next edge.
REQ-037 SHALL cover: 300 alarm entries with C=8 -> num_eventos=255; then rst pulse mid-streak -> all outputs 0 asynchronously.
